manual_drive_ctrl: RTL and testbench

MANUAL_DRIVE_CTRL -- requirements
Module: manual_drive_ctrl

---
 rtl/manual_drive_ctrl_pkg.sv | 24 ++
 rtl/manual_drive_ctrl_tick_gen.sv | 49 ++++
 rtl/manual_drive_ctrl.sv | 125 ++++++++++++
 tb/tb_manual_drive_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manual_drive_ctrl_pkg.sv
// Shared car definitions: drive-state encodings used by the drive controller,
// odometer and display blocks.
package manual_drive_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'b0000,
    ST_NOT_STARTING = 4'b0001,
    ST_STARTING     = 4'b0010,
    ST_MOVING       = 4'b0100
  } drive_state_e;

  // Gear selection may track the lever whenever the drivetrain is not under load.
  function automatic logic gear_may_follow(drive_state_e st, logic clutch_in);
    logic follow;
    case (st)
      ST_NOT_STARTING: follow = 1'b1;
      ST_STARTING:     follow = 1'b1;
      ST_MOVING:       follow = clutch_in;
      default:         follow = 1'b0;
    endcase
    return follow;
  endfunction

endpackage

// File: rtl/manual_drive_ctrl_tick_gen.sv
// Odometer tick generator: counts enabled cycles and emits a registered
// one-cycle pulse every TICK_DIV cycles; disabling discards the partial count.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W   = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;
  logic              tick_q;
  logic              tick_d;

  // Next count and wrap pulse.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == TICK_W'(TICK_DIV - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + TICK_W'(1);
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual driving mode controller: drive-state FSM, gear latch, kill request
// and odometer tick/clear pulses.
module manual_drive_ctrl
  import manual_drive_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TICK_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_now,
  input  logic       manual_sel,
  input  logic       throttle,
  input  logic       clutch,
  input  logic       brake,
  input  logic       reverse,
  output logic [3:0] state,
  output logic       odo_tick,
  output logic       odo_clr,
  output logic       kill,
  output logic       reverse_now
);

  drive_state_e state_q, state_d;
  logic         odo_clr_q, odo_clr_d;
  logic         kill_q, kill_d;
  logic         kill_cond_q, kill_cond_d;
  logic         reverse_now_q, reverse_now_d;
  logic         tick_s;

  // Next-state, gear latch and kill condition.
  always_comb begin
    state_d       = state_q;
    odo_clr_d     = 1'b0;
    kill_cond_d   = 1'b0;
    reverse_now_d = reverse_now_q;

    if (!power_now || !manual_sel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_NOT_STARTING;
          odo_clr_d = 1'b1;
        end
        ST_NOT_STARTING: begin
          if (throttle && clutch && !brake) begin
            state_d = ST_STARTING;
          end else if (throttle && !clutch) begin
            kill_cond_d = 1'b1;
          end else begin
            state_d = ST_NOT_STARTING;
          end
        end
        ST_STARTING: begin
          if (brake) begin
            state_d = ST_NOT_STARTING;
          end else if (throttle && !clutch) begin
            state_d = ST_MOVING;
          end else begin
            state_d = ST_STARTING;
          end
        end
        ST_MOVING: begin
          if (brake) begin
            state_d = ST_NOT_STARTING;
          end else if (clutch) begin
            state_d = ST_STARTING;
          end else begin
            state_d = ST_MOVING;
          end
          // Shifting under load is refused and reported as a kill request.
          if (!clutch && (reverse != reverse_now_q)) begin
            kill_cond_d = 1'b1;
          end else begin
            kill_cond_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (gear_may_follow(state_q, clutch)) begin
      reverse_now_d = reverse;
    end else begin
      reverse_now_d = reverse_now_q;
    end

    kill_d = kill_cond_d && !kill_cond_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      odo_clr_q     <= 1'b0;
      kill_q        <= 1'b0;
      kill_cond_q   <= 1'b0;
      reverse_now_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      odo_clr_q     <= odo_clr_d;
      kill_q        <= kill_d;
      kill_cond_q   <= kill_cond_d;
      reverse_now_q <= reverse_now_d;
    end
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV),
    .TICK_W  (TICK_W)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_MOVING),
    .tick(tick_s)
  );

  assign state       = state_q;
  assign odo_tick    = tick_s;
  assign odo_clr     = odo_clr_q;
  assign kill        = kill_q;
  assign reverse_now = reverse_now_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed bench for manual_drive_ctrl with TICK_DIV=4.
module tb_manual_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       power_now = 1'b0;
  logic       manual_sel = 1'b0;
  logic       throttle = 1'b0;
  logic       clutch = 1'b0;
  logic       brake = 1'b0;
  logic       reverse = 1'b0;
  logic [3:0] state;
  logic       odo_tick;
  logic       odo_clr;
  logic       kill;
  logic       reverse_now;

  int vec_cnt = 0;
  int err_cnt = 0;

  manual_drive_ctrl #(.TICK_DIV(4), .TICK_W(3)) dut (
    .clk(clk), .rst(rst), .power_now(power_now), .manual_sel(manual_sel),
    .throttle(throttle), .clutch(clutch), .brake(brake), .reverse(reverse),
    .state(state), .odo_tick(odo_tick), .odo_clr(odo_clr), .kill(kill),
    .reverse_now(reverse_now)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vec_cnt++;
    if ({state, odo_tick, odo_clr, kill, reverse_now} !== 8'h00) begin
      $display("FAIL reset_outs got %b exp %b", {state, odo_tick, odo_clr, kill, reverse_now}, 8'h00);
      err_cnt++;
    end
    step();
    #2 rst = 1'b1;
    step();
    vec_cnt++;
    if ({state, odo_tick, odo_clr, kill} !== 7'h00) begin
      $display("FAIL reset_release got %b exp %b", {state, odo_tick, odo_clr, kill}, 7'h00);
      err_cnt++;
    end
  endtask

  task automatic test_power_on();
    int clr_n;
    power_now = 1'b1; manual_sel = 1'b1;
    step();
    vec_cnt++;
    if (state !== 4'b0001 || odo_clr !== 1'b1) begin
      $display("FAIL pwr_on got state=%b clr=%b exp state=0001 clr=1", state, odo_clr);
      err_cnt++;
    end
    clr_n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (odo_clr === 1'b1) clr_n++;
    end
    vec_cnt++;
    if (clr_n !== 0 || state !== 4'b0001) begin
      $display("FAIL pwr_on_single_clr got extra=%0d state=%b exp extra=0 state=0001", clr_n, state);
      err_cnt++;
    end
  endtask

  task automatic test_kill_not_starting();
    throttle = 1'b1; clutch = 1'b0;
    step();
    vec_cnt++;
    if (kill !== 1'b1 || state !== 4'b0001) begin
      $display("FAIL ns_kill got kill=%b state=%b exp kill=1 state=0001", kill, state);
      err_cnt++;
    end
    step();
    vec_cnt++;
    if (kill !== 1'b0) begin
      $display("FAIL ns_kill_one_cycle got %b exp 0", kill);
      err_cnt++;
    end
    step();
    vec_cnt++;
    if (kill !== 1'b0 || state !== 4'b0001) begin
      $display("FAIL ns_kill_no_repeat got kill=%b state=%b exp kill=0 state=0001", kill, state);
      err_cnt++;
    end
    throttle = 1'b0;
    step();
    throttle = 1'b1;
    step();
    vec_cnt++;
    if (kill !== 1'b1) begin
      $display("FAIL ns_kill_rearm got %b exp 1", kill);
      err_cnt++;
    end
    throttle = 1'b0;
    step();
  endtask

  task automatic test_drive_ticks();
    int tick_n;
    int bad_pos;
    throttle = 1'b1; clutch = 1'b1;
    step();
    vec_cnt++;
    if (state !== 4'b0010 || kill !== 1'b0) begin
      $display("FAIL to_starting got state=%b kill=%b exp 0010 0", state, kill);
      err_cnt++;
    end
    clutch = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0100) begin
      $display("FAIL to_moving got %b exp 0100", state);
      err_cnt++;
    end
    tick_n = 0; bad_pos = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (odo_tick === 1'b1) begin
        tick_n++;
        if (i % 4 != 0) bad_pos++;
        if (odo_clr === 1'b1) bad_pos++;
      end
    end
    vec_cnt++;
    if (tick_n !== 3) begin
      $display("FAIL tick_count got %0d exp 3", tick_n);
      err_cnt++;
    end
    vec_cnt++;
    if (bad_pos !== 0) begin
      $display("FAIL tick_spacing got %0d misplaced exp 0", bad_pos);
      err_cnt++;
    end
  endtask

  task automatic test_brake_discard();
    int tick_n;
    tick_n = 0;
    step();
    if (odo_tick === 1'b1) tick_n++;
    step();
    if (odo_tick === 1'b1) tick_n++;
    brake = 1'b1; throttle = 1'b1;
    step();
    if (odo_tick === 1'b1) tick_n++;
    vec_cnt++;
    if (state !== 4'b0001) begin
      $display("FAIL brake_prio got %b exp 0001", state);
      err_cnt++;
    end
    brake = 1'b0; throttle = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (odo_tick === 1'b1) tick_n++;
    end
    vec_cnt++;
    if (tick_n !== 0 || state !== 4'b0001) begin
      $display("FAIL brake_discard got ticks=%0d state=%b exp ticks=0 state=0001", tick_n, state);
      err_cnt++;
    end
  endtask

  task automatic test_reverse();
    throttle = 1'b1; clutch = 1'b1;
    step();
    clutch = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0100 || reverse_now !== 1'b0) begin
      $display("FAIL rev_setup got state=%b rev=%b exp 0100 0", state, reverse_now);
      err_cnt++;
    end
    reverse = 1'b1;
    step();
    vec_cnt++;
    if (kill !== 1'b1 || reverse_now !== 1'b0) begin
      $display("FAIL rev_under_load got kill=%b rev=%b exp kill=1 rev=0", kill, reverse_now);
      err_cnt++;
    end
    step();
    vec_cnt++;
    if (kill !== 1'b0 || reverse_now !== 1'b0) begin
      $display("FAIL rev_kill_once got kill=%b rev=%b exp kill=0 rev=0", kill, reverse_now);
      err_cnt++;
    end
    reverse = 1'b0;
    step();
    clutch = 1'b1; reverse = 1'b1;
    step();
    vec_cnt++;
    if (reverse_now !== 1'b1 || kill !== 1'b0 || state !== 4'b0010) begin
      $display("FAIL rev_clutch got rev=%b kill=%b state=%b exp rev=1 kill=0 state=0010", reverse_now, kill, state);
      err_cnt++;
    end
    step();
    vec_cnt++;
    if (kill !== 1'b0 || reverse_now !== 1'b1) begin
      $display("FAIL rev_clutch_hold got kill=%b rev=%b exp kill=0 rev=1", kill, reverse_now);
      err_cnt++;
    end
  endtask

  task automatic test_reset_mid_moving();
    clutch = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0100) begin
      $display("FAIL rst_setup got %b exp 0100", state);
      err_cnt++;
    end
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if ({state, odo_tick, odo_clr, kill, reverse_now} !== 8'h00) begin
      $display("FAIL rst_async got %b exp %b", {state, odo_tick, odo_clr, kill, reverse_now}, 8'h00);
      err_cnt++;
    end
    power_now = 1'b0;
    step();
    #2 rst = 1'b1;
    step();
    vec_cnt++;
    if ({state, odo_tick, odo_clr, kill} !== 7'h00) begin
      $display("FAIL rst_no_tick got %b exp %b", {state, odo_tick, odo_clr, kill}, 7'h00);
      err_cnt++;
    end
  endtask

  task automatic test_power_off();
    throttle = 1'b0; clutch = 1'b0; reverse = 1'b0;
    power_now = 1'b1;
    step();
    throttle = 1'b1; clutch = 1'b1;
    step();
    vec_cnt++;
    if (state !== 4'b0010) begin
      $display("FAIL poff_setup got %b exp 0010", state);
      err_cnt++;
    end
    power_now = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0000) begin
      $display("FAIL poff_starting got %b exp 0000", state);
      err_cnt++;
    end
    power_now = 1'b1; throttle = 1'b0; clutch = 1'b0;
    step();
    throttle = 1'b1; clutch = 1'b1;
    step();
    clutch = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0100) begin
      $display("FAIL poff_setup2 got %b exp 0100", state);
      err_cnt++;
    end
    manual_sel = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0000) begin
      $display("FAIL manual_off_moving got %b exp 0000", state);
      err_cnt++;
    end
    manual_sel = 1'b1; power_now = 1'b0;
    step();
    vec_cnt++;
    if (state !== 4'b0000 || odo_clr !== 1'b0) begin
      $display("FAIL poff_idle got state=%b clr=%b exp 0000 0", state, odo_clr);
      err_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_kill_not_starting();
    test_drive_ticks();
    test_brake_discard();
    test_reverse();
    test_reset_mid_moving();
    test_power_off();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
